// File: rtl/csr_unit_if.sv
// Execute-stage CSR request/response bundle between the core controller and csr_unit.
interface csr_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic        csr_rd;
  logic        csr_wr;
  logic        is_mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output instr_valid, pc, csr_rd, csr_wr, is_mret, csr_addr, csr_wdata,
    output timer_irq, ext_irq,
    input  csr_rdata, redirect, redirect_pc
  );

  modport slave (
    input  instr_valid, pc, csr_rd, csr_wr, is_mret, csr_addr, csr_wdata,
    input  timer_irq, ext_irq,
    output csr_rdata, redirect, redirect_pc
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with interrupt entry, MRET return and a one-cycle
// FLUSH state after every redirect.
module csr_unit (
  input  logic       clk,
  input  logic       rst_n,
  csr_unit_if.slave  bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic        mip_mtip;
  logic        mip_meip;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mcycle;

  logic        active;
  logic        pend_ext;
  logic        pend_tmr;
  logic        take_trap;
  logic        do_mret;
  logic        do_write;

  always_comb begin
    active    = bus.instr_valid && (state == RUN);
    pend_ext  = mie_meie && mip_meip;
    pend_tmr  = mie_mtie && mip_mtip;
    take_trap = active && mstatus_mie && (pend_ext || pend_tmr);
    do_mret   = active && bus.is_mret && !take_trap;
    do_write  = active && bus.csr_wr && !take_trap;
  end

  always_comb begin
    bus.csr_rdata = '0;
    if (bus.csr_rd && bus.instr_valid) begin
      case (bus.csr_addr)
        12'h300: bus.csr_rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
        12'h304: bus.csr_rdata = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
        12'h344: bus.csr_rdata = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};
        12'h305: bus.csr_rdata = mtvec;
        12'h341: bus.csr_rdata = mepc;
        12'h342: bus.csr_rdata = mcause;
        12'hB00: bus.csr_rdata = mcycle;
        default: bus.csr_rdata = '0;
      endcase
    end
  end

  always_comb begin
    bus.redirect    = take_trap || do_mret;
    bus.redirect_pc = '0;
    if (take_trap)    bus.redirect_pc = mtvec;
    else if (do_mret) bus.redirect_pc = mepc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec        <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mcycle       <= '0;
    end else begin
      mip_mtip <= bus.timer_irq;
      mip_meip <= bus.ext_irq;
      mcycle   <= mcycle + 32'd1;
      case (state)
        RUN: begin
          if (take_trap) begin
            mepc         <= {bus.pc[31:2], 2'b00};
            mcause       <= pend_ext ? 32'h8000_000B : 32'h8000_0007;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            state        <= FLUSH;
          end else begin
            if (do_write) begin
              case (bus.csr_addr)
                12'h300: begin
                  mstatus_mie  <= bus.csr_wdata[3];
                  mstatus_mpie <= bus.csr_wdata[7];
                end
                12'h304: begin
                  mie_mtie <= bus.csr_wdata[7];
                  mie_meie <= bus.csr_wdata[11];
                end
                12'h305: mtvec  <= {bus.csr_wdata[31:2], 2'b00};
                12'h341: mepc   <= {bus.csr_wdata[31:2], 2'b00};
                12'h342: mcause <= bus.csr_wdata;
                12'hB00: mcycle <= bus.csr_wdata;
                default: ;
              endcase
            end
            // MRET assignments come after the write so they win on mstatus;
            // both sample the pre-edge MPIE.
            if (do_mret) begin
              mstatus_mie  <= mstatus_mpie;
              mstatus_mpie <= 1'b1;
              state        <= FLUSH;
            end
          end
        end
        FLUSH: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: directed scenarios plus random traffic,
// checked against an address-keyed behavioural model of the CSR file.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_unit_if bus();
  csr_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] rpc;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: CSR values keyed by address, plus flush and mip levels.
  int unsigned csr[int unsigned];
  bit          m_flush;
  bit          m_mipt;
  bit          m_mipe;
  bit          cur_tirq = 1'b0;
  bit          cur_eirq = 1'b0;

  function automatic void model_reset();
    csr.delete();
    csr['h300] = 0;
    csr['h304] = 0;
    csr['h305] = 0;
    csr['h341] = 0;
    csr['h342] = 0;
    csr['hB00] = 0;
    m_flush = 1'b0;
    m_mipt  = 1'b0;
    m_mipe  = 1'b0;
  endfunction

  function automatic int unsigned mip_val();
    return (m_mipt ? 32'h80 : 32'h0) | (m_mipe ? 32'h800 : 32'h0);
  endfunction

  function automatic int unsigned rd_val(int unsigned a);
    if (a == 'h344) return mip_val();
    if (csr.exists(a)) return csr[a];
    return 0;
  endfunction

  function automatic bit trap_now();
    int unsigned pend;
    pend = csr['h304] & mip_val() & 32'h880;
    return !m_flush && bus.instr_valid && ((csr['h300] & 32'h8) != 0) && (pend != 0);
  endfunction

  function automatic exp_t model_out(string tag);
    exp_t e;
    bit   trap;
    bit   mret;
    trap = trap_now();
    mret = !m_flush && bus.instr_valid && bus.is_mret && !trap;
    e.rdata    = (bus.csr_rd && bus.instr_valid) ? rd_val(int'(bus.csr_addr)) : 0;
    e.redirect = trap || mret;
    e.rpc      = trap ? csr['h305] : (mret ? csr['h341] : 0);
    e.tag      = tag;
    return e;
  endfunction

  function automatic void model_edge();
    int unsigned ms_old;
    int unsigned a;
    bit          trap;
    bit          ext;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ms_old = csr['h300];
    trap   = trap_now();
    ext    = (csr['h304] & mip_val() & 32'h800) != 0;
    csr['hB00] = csr['hB00] + 1;
    if (m_flush) begin
      m_flush = 1'b0;
    end else if (bus.instr_valid) begin
      if (trap) begin
        csr['h341] = bus.pc & 32'hFFFF_FFFC;
        csr['h342] = ext ? 32'h8000_000B : 32'h8000_0007;
        csr['h300] = ((ms_old & 32'h8) != 0) ? 32'h80 : 32'h0;
        m_flush = 1'b1;
      end else begin
        if (bus.csr_wr) begin
          a = int'(bus.csr_addr);
          case (a)
            'h300: csr[a] = bus.csr_wdata & 32'h88;
            'h304: csr[a] = bus.csr_wdata & 32'h880;
            'h305, 'h341: csr[a] = bus.csr_wdata & 32'hFFFF_FFFC;
            'h342, 'hB00: csr[a] = bus.csr_wdata;
            default: ;
          endcase
        end
        if (bus.is_mret) begin
          csr['h300] = 32'h80 | (((ms_old & 32'h80) != 0) ? 32'h8 : 32'h0);
          m_flush = 1'b1;
        end
      end
    end
    m_mipt = bus.timer_irq;
    m_mipe = bus.ext_irq;
  endfunction

  // Called 1 time unit after a rising edge; leaves 1 time unit after the next.
  task automatic drive(input bit rst, input bit iv, input bit rd, input bit wr,
                       input bit mret, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] pcv, input string tag, input bit chk = 1'b1);
    rst_n           = rst;
    bus.instr_valid = iv;
    bus.csr_rd      = rd;
    bus.csr_wr      = wr;
    bus.is_mret     = mret;
    bus.csr_addr    = addr;
    bus.csr_wdata   = wd;
    bus.pc          = pcv;
    bus.timer_irq   = cur_tirq;
    bus.ext_irq     = cur_eirq;
    if (chk) sbq.push_back(model_out(tag));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd_csr(input logic [11:0] a, input string tag);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a, 32'h0, 32'h0, tag);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d, input string tag);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, a, d, 32'h0, tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, tag);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (bus.csr_rdata !== e.rdata) begin
        errors++;
        $display("FAIL %s csr_rdata: got %h expected %h", e.tag, bus.csr_rdata, e.rdata);
      end
      checks++;
      if (bus.redirect !== e.redirect) begin
        errors++;
        $display("FAIL %s redirect: got %b expected %b", e.tag, bus.redirect, e.redirect);
      end
      checks++;
      if (bus.redirect_pc !== e.rpc) begin
        errors++;
        $display("FAIL %s redirect_pc: got %h expected %h", e.tag, bus.redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [11:0] addr_pool [9];

  initial begin
    int unsigned r;
    int unsigned wait_cycles;
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'h7C0, 12'h000};
    model_reset();
    #1;
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, "reset", 1'b0);

    foreach (addr_pool[i]) rd_csr(addr_pool[i], "reset_read");
    idle("reset_idle");

    wr_csr(12'h305, 32'h0000_0103, "mtvec_wr");
    rd_csr(12'h305, "mtvec_rd");
    rd_csr(12'h7C0, "unimpl_rd");
    wr_csr(12'h7C0, 32'hFFFF_FFFF, "unimpl_wr");
    rd_csr(12'h7C0, "unimpl_rd2");

    wr_csr(12'h304, 32'h0000_0800, "meie_wr");
    wr_csr(12'h300, 32'h0000_0008, "mie_wr");
    cur_eirq = 1'b1;
    idle("irq_settle");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h40, "ext_take");
    rd_csr(12'h341, "flush_mepc");
    rd_csr(12'h342, "ext_mcause");
    rd_csr(12'h300, "ext_mstatus");

    cur_tirq = 1'b1;
    wr_csr(12'h304, 32'h0000_0880, "both_en");
    wr_csr(12'h300, 32'h0000_0008, "both_mie");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h100, "both_take");
    idle("both_flush");
    rd_csr(12'h342, "both_mcause");
    wr_csr(12'h304, 32'h0000_0080, "tmr_only_en");
    wr_csr(12'h300, 32'h0000_0008, "tmr_mie");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h200, "tmr_take");
    idle("tmr_flush");
    rd_csr(12'h342, "tmr_mcause");
    cur_tirq = 1'b0;
    cur_eirq = 1'b0;
    idle("irq_clear");

    wr_csr(12'h341, 32'h0000_0080, "mepc_wr");
    wr_csr(12'h300, 32'h0000_0080, "mpie_wr");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h44, "mret");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h48, "mret_in_flush");
    rd_csr(12'h300, "mret_mstatus");

    wr_csr(12'h304, 32'h0000_0800, "mie_pre");
    cur_eirq = 1'b1;
    idle("irq_settle2");
    wr_csr(12'h304, 32'h0000_0000, "mie_wr_on_trap");
    idle("wr_trap_flush");
    cur_eirq = 1'b0;
    rd_csr(12'h304, "mie_kept");
    wr_csr(12'hB00, 32'hFFFF_FFFF, "mcycle_wr");
    idle("mcycle_wrap");
    rd_csr(12'hB00, "mcycle_rd");

    wr_csr(12'h300, 32'h0000_0008, "rst_mie");
    cur_eirq = 1'b1;
    idle("rst_settle");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h300, "rst_take");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h305, 32'h1234, 32'h0, "rst_in_flush");
    cur_eirq = 1'b0;
    idle("post_rst");
    foreach (addr_pool[i]) rd_csr(addr_pool[i], "post_rst_read");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0, 32'h0, "post_rst_mret");

    for (int n = 0; n < 1500; n++) begin
      r = $urandom;
      if ($urandom_range(7) == 0) cur_tirq = ~cur_tirq;
      if ($urandom_range(7) == 0) cur_eirq = ~cur_eirq;
      drive(($urandom_range(63) != 0),
            ($urandom_range(4) != 0),
            r[0], (r[3:1] < 3'd3), (r[7:4] == 4'd0),
            addr_pool[$urandom_range(8)],
            ($urandom_range(1) == 0) ? 32'h0000_0888 : $urandom,
            $urandom & 32'hFFFF_FFFC, "random");
    end
    idle("tail");

    wait_cycles = 0;
    while (sbq.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
